// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment: lock/request
// inputs towards the sequencer, sequenced resets and status back out.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 8
);
    logic                  locked_in;
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] rst_stage_n;
    logic                  sys_ready;
    logic [CNT_W-1:0]      lock_loss_cnt;
    logic [2:0]            seq_state;

    modport master (
        output locked_in,
        output sw_rst_req,
        input  rst_stage_n,
        input  sys_ready,
        input  lock_loss_cnt,
        input  seq_state
    );

    modport slave (
        input  locked_in,
        input  sw_rst_req,
        output rst_stage_n,
        output sys_ready,
        output lock_loss_cnt,
        output seq_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Qualifies the asynchronous PLL lock flag and releases per-subsystem resets in
// fixed order; re-asserts everything on lock loss or a software re-sequence request.
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY   = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.slave  seq_if
);

    localparam int TMR_MAX = (STABLE_CYCLES > STAGE_DELAY) ? STABLE_CYCLES : STAGE_DELAY;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3
    } state_e;

    state_e                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic                  ready_q, ready_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  locked_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            sat_inc = val;
        end else begin
            sat_inc = val + CNT_W'(1);
        end
    endfunction

    // Lock flag synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], seq_if.locked_in};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT_LOCK;
            timer_q <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; lock loss outranks the software request
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                rst_n_d = '0;
                ready_d = 1'b0;
                timer_d = '0;
                idx_d   = '0;
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_RELEASE;
                    timer_d = '0;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!locked_s) begin
                    rst_n_d = '0;
                    ready_d = 1'b0;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                    idx_d   = '0;
                end else if (timer_q == DELAY_LAST) begin
                    rst_n_d[idx_q] = 1'b1;
                    timer_d        = '0;
                    if (idx_q == IDX_LAST) begin
                        ready_d = 1'b1;
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    rst_n_d = '0;
                    ready_d = 1'b0;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                    idx_d   = '0;
                end else if (seq_if.sw_rst_req) begin
                    rst_n_d = '0;
                    ready_d = 1'b0;
                    state_d = ST_STABLE;
                    timer_d = '0;
                    idx_d   = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Unreachable encodings fall back to the fully-reset state
                rst_n_d = '0;
                ready_d = 1'b0;
                state_d = ST_WAIT_LOCK;
                timer_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign seq_if.rst_stage_n   = rst_n_q;
    assign seq_if.sys_ready     = ready_q;
    assign seq_if.lock_loss_cnt = cnt_q;
    assign seq_if.seq_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short qualify/stage windows; every
// expected value is hand-derived edge counts from the first lock-sampling edge.
module tb_reset_sequencer;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    reset_sequencer_if #(.NUM_STAGES(3), .CNT_W(8)) seq_if ();

    reset_sequencer #(
        .NUM_STAGES   (3),
        .STABLE_CYCLES(8),
        .STAGE_DELAY  (4),
        .SYNC_STAGES  (2),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .seq_if(seq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance n active edges, then settle 1 time unit
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] rst, input logic rdy,
                           input logic [2:0] st);
        chk({tag, ".rst"},   32'(seq_if.rst_stage_n), 32'(rst));
        chk({tag, ".ready"}, 32'(seq_if.sys_ready),   32'(rdy));
        chk({tag, ".state"}, 32'(seq_if.seq_state),   32'(st));
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        reset             = 1'b1;
        seq_if.locked_in  = 1'b1;
        seq_if.sw_rst_req = 1'b0;

        // 1: reset values
        step(3);
        chk_all("rst", 3'b000, 1'b0, 3'd0);
        chk("rst.cnt", 32'(seq_if.lock_loss_cnt), 32'd0);

        // 2: initial sequence, edge 1 = first sample of locked_in
        reset = 1'b0;
        step(2);
        chk("seq.e2.state", 32'(seq_if.seq_state), 32'd0);
        step(1);
        chk("seq.e3.state", 32'(seq_if.seq_state), 32'd1);
        step(8);
        chk("seq.e11.state", 32'(seq_if.seq_state), 32'd2);
        step(3);
        chk("seq.e14.rst", 32'(seq_if.rst_stage_n), 32'b000);
        step(1);
        chk("seq.e15.rst", 32'(seq_if.rst_stage_n), 32'b001);
        step(3);
        chk("seq.e18.rst", 32'(seq_if.rst_stage_n), 32'b001);
        step(1);
        chk("seq.e19.rst", 32'(seq_if.rst_stage_n), 32'b011);
        step(3);
        chk_all("seq.e22", 3'b011, 1'b0, 3'd2);
        step(1);
        chk_all("seq.e23", 3'b111, 1'b1, 3'd3);

        // 3: one-cycle lock drop in RUN
        seq_if.locked_in = 1'b0;
        step(1);
        seq_if.locked_in = 1'b1;
        step(1);
        chk_all("loss.e1", 3'b111, 1'b1, 3'd3);
        step(1);
        chk_all("loss.e2", 3'b000, 1'b0, 3'd0);
        chk("loss.cnt", 32'(seq_if.lock_loss_cnt), 32'd1);
        step(1);
        chk("relock.state", 32'(seq_if.seq_state), 32'd1);
        step(11);
        chk("relock.e14.rst", 32'(seq_if.rst_stage_n), 32'b000);
        step(1);
        chk("relock.e15.rst", 32'(seq_if.rst_stage_n), 32'b001);
        step(8);
        chk_all("relock.e23", 3'b111, 1'b1, 3'd3);

        // 5: software re-sequence from RUN
        seq_if.sw_rst_req = 1'b1;
        step(1);
        seq_if.sw_rst_req = 1'b0;
        chk_all("sw.s0", 3'b000, 1'b0, 3'd1);
        step(19);
        chk_all("sw.s19", 3'b011, 1'b0, 3'd2);
        step(1);
        chk_all("sw.s20", 3'b111, 1'b1, 3'd3);
        chk("sw.cnt", 32'(seq_if.lock_loss_cnt), 32'd1);

        // 5b: request during RELEASE is ignored
        seq_if.sw_rst_req = 1'b1;
        step(1);
        seq_if.sw_rst_req = 1'b0;
        step(9);
        seq_if.sw_rst_req = 1'b1;
        step(1);
        seq_if.sw_rst_req = 1'b0;
        chk_all("swrel.s10", 3'b000, 1'b0, 3'd2);
        step(2);
        chk("swrel.s12.rst", 32'(seq_if.rst_stage_n), 32'b001);
        step(8);
        chk_all("swrel.s20", 3'b111, 1'b1, 3'd3);

        // 4: glitch during STABLE restarts the window, not counted
        seq_if.sw_rst_req = 1'b1;
        step(1);
        seq_if.sw_rst_req = 1'b0;
        step(3);
        seq_if.locked_in = 1'b0;
        step(1);
        seq_if.locked_in = 1'b1;
        step(1);
        chk("glitch.s5.state", 32'(seq_if.seq_state), 32'd1);
        step(1);
        chk("glitch.s6.state", 32'(seq_if.seq_state), 32'd0);
        chk("glitch.cnt", 32'(seq_if.lock_loss_cnt), 32'd1);
        step(1);
        chk("glitch.s7.state", 32'(seq_if.seq_state), 32'd1);
        step(7);
        chk("glitch.s14.state", 32'(seq_if.seq_state), 32'd1);
        step(1);
        chk("glitch.s15.state", 32'(seq_if.seq_state), 32'd2);
        step(3);
        chk("glitch.s18.rst", 32'(seq_if.rst_stage_n), 32'b000);
        step(1);
        chk("glitch.s19.rst", 32'(seq_if.rst_stage_n), 32'b001);
        step(8);
        chk_all("glitch.s27", 3'b111, 1'b1, 3'd3);

        // 6: 259 further losses (260 total) saturate the counter
        for (int i = 0; i < 259; i++) begin
            seq_if.locked_in = 1'b0;
            step(1);
            seq_if.locked_in = 1'b1;
            step(2);
            if (i == 0) chk("sat.first", 32'(seq_if.lock_loss_cnt), 32'd2);
            if (i == 252) chk("sat.254", 32'(seq_if.lock_loss_cnt), 32'd254);
            if (i == 253) chk("sat.255", 32'(seq_if.lock_loss_cnt), 32'd255);
            step(9);
        end
        chk("sat.final", 32'(seq_if.lock_loss_cnt), 32'd255);
        chk("sat.state", 32'(seq_if.seq_state), 32'd2);

        // 6b: reset mid-RELEASE
        step(4);
        chk_all("midrst.pre", 3'b001, 1'b0, 3'd2);
        reset = 1'b1;
        step(1);
        chk_all("midrst", 3'b000, 1'b0, 3'd0);
        chk("midrst.cnt", 32'(seq_if.lock_loss_cnt), 32'd0);
        reset = 1'b0;
        step(3);
        chk("midrst.requal", 32'(seq_if.seq_state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
